// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: definitions shared by the mul/div sequencer and its users.
//   - mds_state_e          : 3-bit FSM state encoding
//   - MDS_MUL_CYCLES_DEF   : default number of multiply steps
//   - MDS_DIV_STEPS_DEF    : default number of divide cycles before the last one
//   - mds_cnt_width()      : step counter width for a given parameter pair
package muldiv_sequencer_pkg;

  typedef enum logic [2:0] {
    MDS_IDLE  = 3'd0,
    MDS_MUL   = 3'd1,
    MDS_DIV   = 3'd2,
    MDS_DLAST = 3'd3,
    MDS_FIN   = 3'd4
  } mds_state_e;

  localparam int MDS_MUL_CYCLES_DEF = 4;
  localparam int MDS_DIV_STEPS_DEF  = 16;

  // One bit of headroom above what the larger step count needs.
  function automatic int mds_cnt_width(input int mul_cycles, input int div_steps);
    return $clog2((mul_cycles > div_steps) ? mul_cycles : div_steps) + 1;
  endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: ID-stage side of the mul/div sequencer.
//   master : ID decode / pipeline control (drives requests, reads step controls)
//   slave  : muldiv_sequencer
//   enable_i, flush_i, is_m_i, is_d_i    : requests and pipeline control
//   mul_state_o, d_init_o, d_advance_o,
//   div_last_o, fin_o, busy_o, stall_o   : step controls and hazard request
interface muldiv_sequencer_if;
  logic       enable_i;
  logic       flush_i;
  logic       is_m_i;
  logic       is_d_i;
  logic [1:0] mul_state_o;
  logic       d_init_o;
  logic       d_advance_o;
  logic       div_last_o;
  logic       fin_o;
  logic       busy_o;
  logic       stall_o;

  modport master (
    output enable_i, flush_i, is_m_i, is_d_i,
    input  mul_state_o, d_init_o, d_advance_o, div_last_o, fin_o, busy_o, stall_o
  );

  modport slave (
    input  enable_i, flush_i, is_m_i, is_d_i,
    output mul_state_o, d_init_o, d_advance_o, div_last_o, fin_o, busy_o, stall_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: one FSM plus step counter that sequences multi-cycle
// multiply/divide instructions held in ID and produces the EXE mul/div step
// controls and the ID stall request.
//   clk    : clock
//   resetn : asynchronous active-low reset
//   bus    : muldiv_sequencer_if.slave (requests in, step controls out)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation; a request here is cycle 0 (mul step 0 / d_init)
// MUL   | multiply steps 1..MUL_CYCLES-1, cnt is the step index
// DIV   | divide advance cycles 1..DIV_STEPS-1
// DLAST | final divide cycle (sign fix-up)
// FIN   | result valid, instruction leaves ID on the next enabled edge
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int MUL_CYCLES = MDS_MUL_CYCLES_DEF,
  parameter int DIV_STEPS  = MDS_DIV_STEPS_DEF
) (
  input logic                 clk,
  input logic                 resetn,
  muldiv_sequencer_if.slave   bus
);

  localparam int CNT_W = mds_cnt_width(MUL_CYCLES, DIV_STEPS);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mds_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_idle;
  logic             req_live;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MDS_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush_i) begin
      state_d = MDS_IDLE;
      cnt_d   = '0;
    end else if (bus.enable_i) begin
      unique case (state_q)
        MDS_IDLE: begin
          // Multiply wins when decode flags both.
          if (bus.is_m_i) begin
            state_d = MDS_MUL;
            cnt_d   = CNT_ONE;
          end else if (bus.is_d_i) begin
            state_d = MDS_DIV;
            cnt_d   = CNT_ONE;
          end
        end
        MDS_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d = MDS_FIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        MDS_DIV: begin
          if (cnt_q == DIV_LAST) begin
            state_d = MDS_DLAST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        MDS_DLAST: state_d = MDS_FIN;
        MDS_FIN:   state_d = MDS_IDLE;
        default: begin
          state_d = MDS_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign in_idle = (state_q == MDS_IDLE);

  // The IDLE-cycle outputs depend on live request inputs; gating with resetn
  // keeps every output low while reset is held, even with a request present.
  assign req_live = resetn & in_idle & ~bus.flush_i;

  assign bus.mul_state_o = (in_idle || state_q == MDS_MUL) ? cnt_q[1:0] : 2'b00;
  assign bus.d_init_o    = req_live & bus.is_d_i & ~bus.is_m_i;
  assign bus.d_advance_o = (state_q == MDS_DIV);
  assign bus.div_last_o  = (state_q == MDS_DLAST);
  assign bus.fin_o       = (state_q == MDS_FIN);
  assign bus.busy_o      = ~in_idle;
  assign bus.stall_o     = (state_q == MDS_MUL) | (state_q == MDS_DIV) |
                           (state_q == MDS_DLAST) |
                           (req_live & (bus.is_m_i | bus.is_d_i));

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.MUL_CYCLES(4), .DIV_STEPS(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // exp bits: {mul_state[1:0], d_init, d_adv, div_last, fin, busy, stall}
  typedef struct {
    logic       m, d, en, fl;
    logic [7:0] exp;
  } vec_t;

  vec_t       vec_q[$];
  logic [7:0] sb_q[$];
  int         total = 0;
  int         bad   = 0;

  function automatic logic [7:0] outs();
    return {bus.mul_state_o, bus.d_init_o, bus.d_advance_o, bus.div_last_o,
            bus.fin_o, bus.busy_o, bus.stall_o};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (ms,init,adv,last,fin,busy,stall)", name, act, exp);
    end
  endtask

  task automatic add(input logic m, d, en, fl, input logic [1:0] ms,
                     input logic di, da, dl, fin, busy, st);
    vec_t v;
    v.m = m; v.d = d; v.en = en; v.fl = fl;
    v.exp = {ms, di, da, dl, fin, busy, st};
    vec_q.push_back(v);
  endtask

  task automatic add_idle();
    add(0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic add_mul_start();
    add(1, 0, 1, 0, 2'd0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic add_mul_tail();
    for (int k = 1; k <= 3; k++) add(1, 0, 1, 0, 2'(k), 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
  endtask

  task automatic add_div_start();
    add(0, 1, 1, 0, 2'd0, 1, 0, 0, 0, 0, 1);
  endtask

  task automatic add_div_adv();
    add(0, 1, 1, 0, 2'd0, 0, 1, 0, 0, 1, 1);
  endtask

  initial begin
    logic [7:0] got;
    logic [7:0] e;

    // MUL from reset release
    add_mul_start(); add_mul_tail(); add_idle();
    // full DIV: d_init c0, advance c1..15, last c16, fin c17
    add_div_start();
    for (int k = 1; k <= 15; k++) add_div_adv();
    add(0, 1, 1, 0, 2'd0, 0, 0, 1, 0, 1, 1);
    add(0, 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    add_idle();
    // DIV flushed in cycle 8, then a MUL completes at +4
    add_div_start();
    for (int k = 1; k <= 7; k++) add_div_adv();
    add(0, 1, 1, 1, 2'd0, 0, 1, 0, 0, 1, 1);
    add_idle();
    add_mul_start(); add_mul_tail(); add_idle();
    // MUL frozen in cycles 2-4
    add_mul_start();
    add(1, 0, 1, 0, 2'd1, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 2'd2, 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 2'd2, 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 2'd3, 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    add_idle();
    // freeze while in FIN: fin held until first enabled edge
    add_mul_start();
    for (int k = 1; k <= 3; k++) add(1, 0, 1, 0, 2'(k), 0, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    add_idle();
    // both flags: multiply wins; then back-to-back DIV right after FIN
    add(1, 1, 1, 0, 2'd0, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) add(1, 1, 1, 0, 2'(k), 0, 0, 0, 0, 1, 1);
    add(1, 1, 1, 0, 2'd0, 0, 0, 0, 1, 1, 0);
    add_div_start();
    add(0, 1, 1, 1, 2'd0, 0, 1, 0, 0, 1, 1);
    add_idle();
    // flush coinciding with FIN
    add_mul_start();
    for (int k = 1; k <= 3; k++) add(1, 0, 1, 0, 2'(k), 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 1, 2'd0, 0, 0, 0, 1, 1, 0);
    add_idle();
    // flush while a request sits in IDLE: no stall, no start
    add(1, 0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0);
    add_idle();
    // request in IDLE while frozen: stall, but no start
    add(1, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 1);
    add_mul_start(); add_mul_tail(); add_idle();
    // DIV start, interrupted by async reset afterwards
    add_div_start(); add_div_adv(); add_div_adv();

    // reset held with a multiply request present
    resetn = 1'b0;
    bus.enable_i = 1'b1; bus.flush_i = 1'b0; bus.is_m_i = 1'b1; bus.is_d_i = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk("reset_outputs", outs(), 8'b0);
    @(posedge clk);
    #1 resetn = 1'b1;

    foreach (vec_q[i]) begin
      bus.is_m_i   = vec_q[i].m;
      bus.is_d_i   = vec_q[i].d;
      bus.enable_i = vec_q[i].en;
      bus.flush_i  = vec_q[i].fl;
      sb_q.push_back(vec_q[i].exp);
      #5;
      got = outs();
      e   = sb_q.pop_front();
      chk($sformatf("vec%0d", i), got, e);
      total++;
      if ($countones(got[5:2]) > 1) begin
        bad++;
        $display("FAIL step_exclusive vec%0d: got %b want at most one of init/adv/last/fin", i, got[5:2]);
      end
      @(posedge clk);
      #1;
    end

    // now mid-DIV (cnt=3): async reset between edges clears outputs at once
    chk("pre_reset_busy", {7'b0, bus.busy_o}, 8'b1);
    #2 resetn = 1'b0;
    #1 chk("async_reset_outputs", outs(), 8'b0);
    @(posedge clk);
    #1;
    bus.is_d_i = 1'b0;
    resetn = 1'b1;
    #5 chk("after_reset_idle", outs(), 8'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Sequences the multi-cycle multiply and divide operations issued from the ID stage.
- Replaces the ad-hoc mul/div counters inside the ID stage with one FSM that produces the step controls the EXE-stage mul/div datapath consumes: mul_state, d_init, d_advance, div_last and fin.
- Drives a stall request to the hazard unit so the mul/div instruction is held in ID until its result completes.
- Sits between ID decode outputs and the ID/EXE pipeline register.

Parameters:
- MUL_CYCLES, 4: number of multiply steps. mul_state_o counts 0..MUL_CYCLES-1. Legal range 2..4.
- DIV_STEPS, 16: number of divide cycles before the last cycle. Covers 1 init cycle plus DIV_STEPS-1 advance cycles. Legal range 2..16.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- enable_i  in  1  ID stage enable. When low, the FSM freezes.
- flush_i  in  1  pipeline flush. Aborts any operation in progress.
- is_m_i  in  1  ID instruction is MUL/MULH/MULHSU/MULHU.
- is_d_i  in  1  ID instruction is DIV/DIVU/REM/REMU.
- mul_state_o  out  2  current multiply step index.
- d_init_o  out  1  first divide cycle (load operands).
- d_advance_o  out  1  divide iteration cycle.
- div_last_o  out  1  final divide cycle (sign fix-up).
- fin_o  out  1  result valid this cycle; the instruction may leave ID.
- busy_o  out  1  FSM not in IDLE.
- stall_o  out  1  hold IF/ID this cycle.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, cnt=0.
  - All outputs 0.
  - Release is synchronous to the next clk edge.
- States: IDLE, MUL, DIV, DLAST, FIN. Encoding comes from the shared package.
- cnt register width: $clog2(max(MUL_CYCLES, DIV_STEPS))+1.
- mul_state_o = cnt[1:0] while in IDLE or MUL, 0 otherwise.
- Priority per edge: resetn > flush_i > ~enable_i (freeze: state, cnt and outputs hold) > normal transitions.
- IDLE:
  - is_m_i=1 → MUL, cnt←1. is_m_i wins if is_m_i and is_d_i are both high.
  - is_d_i=1 → DIV, cnt←1. d_init_o=1 combinationally this cycle.
  - Otherwise stay in IDLE.
- MUL:
  - If cnt==MUL_CYCLES-1 → FIN, cnt←0.
  - Else cnt←cnt+1.
- DIV:
  - d_advance_o=1.
  - If cnt==DIV_STEPS-1 → DLAST, cnt←0.
  - Else cnt←cnt+1.
- DLAST: div_last_o=1, d_advance_o=0. → FIN.
- FIN:
  - fin_o=1 for exactly one enabled cycle, then → IDLE unconditionally.
  - is_m_i/is_d_i still high in FIN does not retrigger; the instruction leaves ID on this edge.
- stall_o = (state ∈ {MUL, DIV, DLAST}) | (state==IDLE & (is_m_i|is_d_i) & ~flush_i). stall_o=0 in FIN.
- busy_o = state≠IDLE.
- Latency, measured from the first IDLE cycle with the request (cycle 0):
  - multiply: fin_o at cycle MUL_CYCLES (default 4). mul_state_o=0,1,2,3 in cycles 0..3.
  - divide: d_init at cycle 0, d_advance at cycles 1..DIV_STEPS-1, div_last at cycle DIV_STEPS, fin_o at cycle DIV_STEPS+1 (default 17).
- Freeze: with enable_i=0 in FIN, fin_o stays 1 until the first enabled edge. Counting is resumed, not restarted.
- Flush mid-operation:
  - Next edge: IDLE, cnt=0, all step outputs 0.
  - No fin_o is produced for the aborted operation.
  - A flush coinciding with FIN still returns to IDLE (same edge).
- Back-to-back: FIN → IDLE. The next mul/div starts in the IDLE cycle that follows. Minimum one cycle with busy_o=0 between operations.

Decomposition:
- Shared package (definitions.vh): state encodings MDS_IDLE/MDS_MUL/MDS_DIV/MDS_DLAST/MDS_FIN (3 bits), default MUL_CYCLES/DIV_STEPS constants.
- No sub-module needed: a single FSM plus one counter.

Test Plan:
- Reset with is_m_i=1 held → all outputs 0. First edge after release: mul_state 0→1, stall_o=1.
- MUL, enable=1 → mul_state_o 0,1,2,3; fin_o=1 at cycle 4 only; stall_o high cycles 0–3, low at cycle 4; busy_o low at cycle 5.
- DIV, enable=1 → d_init_o at cycle 0; d_advance_o cycles 1–15 (15 pulses); div_last_o cycle 16; fin_o cycle 17; never two step outputs high together.
- DIV with flush_i at cycle 8 → cycle 9: IDLE, d_advance_o=0, fin_o never asserts; new is_m_i then completes with fin at +4.
- MUL with enable_i=0 during cycles 2–4 → mul_state_o holds at 2; fin_o arrives at cycle 7.
- is_m_i and is_d_i both high in IDLE → MUL path taken, d_init_o=0. Async reset asserted mid-DIV (between edges) → outputs 0 immediately.
